// File: rtl/wb_pipe.sv
// MEM/WB pipeline register: picks the write-back source, extracts sub-word loads,
// and masks writes to r0. Also counts retired instructions for debug and performance.
module wb_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic [REG_AW-1:0] i_write_reg,
    input  logic [DATA_W-1:0] i_result,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic [DATA_W-1:0] i_link,
    input  logic [1:0]        i_wb_sel,
    input  logic              i_reg_write,
    input  logic [1:0]        i_ld_size,
    input  logic              i_ld_unsigned,
    input  logic [1:0]        i_byte_off,
    output logic [REG_AW-1:0] o_write_reg,
    output logic [DATA_W-1:0] o_write_data,
    output logic              o_reg_write,
    output logic              o_valid,
    output logic [CNT_W-1:0]  o_retired
);

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_LINK = 2'b10,
        WB_ALT  = 2'b11
    } wb_sel_e;

    logic [31:0]       word_lane;
    logic [15:0]       half_lane;
    logic [7:0]        byte_lane;
    logic [DATA_W-1:0] load_ext;
    logic [DATA_W-1:0] wb_data;

    logic              valid_q,      valid_d;
    logic              reg_write_q,  reg_write_d;
    logic [REG_AW-1:0] write_reg_q,  write_reg_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic [CNT_W-1:0]  retired_q,    retired_d;

    // Lanes are always taken from the low 32 bits; the size cast does the extension.
    always_comb begin
        word_lane = i_mem_data[31:0];
        byte_lane = word_lane[{i_byte_off, 3'b000} +: 8];
        half_lane = word_lane[{i_byte_off[1], 4'b0000} +: 16];
        load_ext  = '0;
        case (i_ld_size)
            2'b00: begin
                if (i_ld_unsigned) load_ext = DATA_W'(byte_lane);
                else               load_ext = DATA_W'($signed(byte_lane));
            end
            2'b01: begin
                if (i_ld_unsigned) load_ext = DATA_W'(half_lane);
                else               load_ext = DATA_W'($signed(half_lane));
            end
            default: begin
                if (i_ld_unsigned) load_ext = DATA_W'(word_lane);
                else               load_ext = DATA_W'($signed(word_lane));
            end
        endcase
    end

    always_comb begin
        wb_data = i_result;
        case (wb_sel_e'(i_wb_sel))
            WB_LOAD: wb_data = load_ext;
            WB_LINK: wb_data = i_link;
            default: wb_data = i_result;
        endcase
    end

    // NOTE: every _d starts at its _q value, so the hold path is explicit and no latch is inferred.
    always_comb begin
        valid_d      = valid_q;
        reg_write_d  = reg_write_q;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        retired_d    = retired_q;
        if (i_flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
        end else if (!i_stall) begin
            valid_d      = i_valid;
            reg_write_d  = i_reg_write;
            write_reg_d  = i_write_reg;
            write_data_d = wb_data;
            if (i_valid) retired_d = retired_q + CNT_W'(1);
        end
    end

    // NOTE: the reset is synchronous, so it is tested inside the clocked branch and not listed as an event.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            retired_q    <= '0;
        end else begin
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            retired_q    <= retired_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_write_reg  = write_reg_q;
    assign o_write_data = write_data_q;
    assign o_retired    = retired_q;
    assign o_reg_write  = valid_q & reg_write_q & (write_reg_q != '0);

endmodule
